fetch_pc: RTL and testbench

//  Architectural program counter and instruction fetch for the sequential core.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_next_pc.sv | 28 ++
 rtl/fetch_pc.sv | 119 +++++++++++
 tb/tb_fetch_pc.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the fetch/PC unit.
// Holds the FSM state enum and the default reset PC.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_FETCH,
    ST_EXEC,
    ST_FAULT
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0;

endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: priority mux of set > add > inc plus PC adder.
// Ports: cur_pc, pc_target, strobes in; next_pc, strobe out.
module fetch_next_pc #(
  parameter int ADDR_W = 31
) (
  input  logic [ADDR_W-1:0] cur_pc,
  input  logic [ADDR_W-1:0] pc_target,
  input  logic              pc_set,
  input  logic              pc_add,
  input  logic              pc_inc,
  output logic [ADDR_W-1:0] next_pc,
  output logic              strobe
);

  assign strobe = pc_set | pc_add | pc_inc;

  always_comb begin
    next_pc = cur_pc;
    if (pc_set) begin
      next_pc = pc_target;
    end else if (pc_add) begin
      next_pc = cur_pc + pc_target;
    end else if (pc_inc) begin
      next_pc = cur_pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_pc.sv
// fetch_pc: architectural PC, imem req/ack fetch, instr latch.
// Ports: cpu_clk/rst, PC strobes, imem bus, decode outputs.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int              ADDR_W   = 31,
  parameter int              INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC =
    ADDR_W'(RESET_PC_DEF),
  parameter int              CNT_W    = 32
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic               pc_set,
  input  logic               pc_add,
  input  logic               pc_inc,
  input  logic [ADDR_W-1:0]  pc_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_err,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  cur_pc,
  output logic               fault,
  output logic [CNT_W-1:0]   instret
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic               fault_q, fault_d;

  logic [ADDR_W-1:0]  next_pc;
  logic               strobe;

  fetch_next_pc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .cur_pc    (pc_q),
    .pc_target (pc_target),
    .pc_set    (pc_set),
    .pc_add    (pc_add),
    .pc_inc    (pc_inc),
    .next_pc   (next_pc),
    .strobe    (strobe)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    ipc_d     = ipc_q;
    instret_d = instret_q;
    fault_d   = fault_q;
    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          if (imem_err) begin
            fault_d = 1'b1;
            state_d = ST_FAULT;
          end else begin
            instr_d = imem_rdata;
            ipc_d   = pc_q;
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (strobe) begin
          pc_d      = next_pc;
          instret_d = instret_q + CNT_W'(1);
          state_d   = ST_FETCH;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      ipc_q     <= '0;
      instret_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      ipc_q     <= ipc_d;
      instret_q <= instret_d;
      fault_q   <= fault_d;
    end
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == ST_EXEC);
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign cur_pc      = pc_q;
  assign fault       = fault_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_fetch_pc.sv
// tb_fetch_pc: directed vector table plus corner sequences.
// Checks fetch_pc outputs against hand-computed values.
module tb_fetch_pc;

  logic        clk = 1'b0;
  logic        rst;
  logic        set, add, inc;
  logic [30:0] tgt;
  logic        req;
  logic [30:0] addr;
  logic        ack;
  logic [15:0] rdata;
  logic        err;
  logic        valid;
  logic [15:0] instr;
  logic [30:0] ipc;
  logic [30:0] pc;
  logic        fault;
  logic [31:0] ir;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_pc dut (
    .cpu_clk     (clk),
    .cpu_rst     (rst),
    .pc_set      (set),
    .pc_add      (add),
    .pc_inc      (inc),
    .pc_target   (tgt),
    .imem_req    (req),
    .imem_addr   (addr),
    .imem_ack    (ack),
    .imem_rdata  (rdata),
    .imem_err    (err),
    .instr_valid (valid),
    .instr       (instr),
    .instr_pc    (ipc),
    .cur_pc      (pc),
    .fault       (fault),
    .instret     (ir)
  );

  typedef struct {
    logic        set, add, inc;
    logic [30:0] tgt;
    logic        ack;
    logic [15:0] rdata;
    logic        err;
    logic        req;
    logic [30:0] addr;
    logic        valid;
    logic [15:0] instr;
    logic [30:0] ipc;
    logic [30:0] pc;
    logic        fault;
    logic [31:0] ir;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic s, logic a, logic i, logic [30:0] t,
    logic k, logic [15:0] d, logic e,
    logic xr, logic [30:0] xa, logic xv,
    logic [15:0] xi, logic [30:0] xp,
    logic [30:0] xc, logic xf, logic [31:0] xn);
    vec_t v;
    v.set = s; v.add = a; v.inc = i; v.tgt = t;
    v.ack = k; v.rdata = d; v.err = e;
    v.req = xr; v.addr = xa; v.valid = xv;
    v.instr = xi; v.ipc = xp; v.pc = xc;
    v.fault = xf; v.ir = xn;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic xr,
    logic [30:0] xa, logic xv, logic [15:0] xi,
    logic [30:0] xp, logic [30:0] xc, logic xf,
    logic [31:0] xn);
    chk({tag, ".req"}, 32'(req), 32'(xr));
    if (xr) chk({tag, ".addr"}, 32'(addr), 32'(xa));
    chk({tag, ".valid"}, 32'(valid), 32'(xv));
    chk({tag, ".instr"}, 32'(instr), 32'(xi));
    chk({tag, ".ipc"}, 32'(ipc), 32'(xp));
    chk({tag, ".pc"}, 32'(pc), 32'(xc));
    chk({tag, ".fault"}, 32'(fault), 32'(xf));
    chk({tag, ".instret"}, ir, xn);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set = 0; add = 0; inc = 0; tgt = '0;
    ack = 0; rdata = '0; err = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  initial begin
    rst = 0;
    idle();
    #2;

    // r: set add inc tgt ack rdata err | exp
    vecs.push_back(mk(0,0,0,0, 1,16'hFFFF,0,
      0,0,0,16'h0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,16'hA001,0,
      1,0,0,16'h0,0,0,0,0));
    vecs.push_back(mk(0,0,1,31'h55, 0,0,0,
      0,0,1,16'hA001,0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,16'hB002,0,
      1,1,0,16'hA001,0,1,0,1));
    vecs.push_back(mk(0,1,0,31'h7FFFFFFE, 0,0,0,
      0,0,1,16'hB002,1,1,0,1));
    vecs.push_back(mk(0,0,0,0, 1,16'hC003,0,
      1,31'h7FFFFFFF,0,16'hB002,1,
      31'h7FFFFFFF,0,2));
    vecs.push_back(mk(0,0,1,0, 0,0,0,
      0,0,1,16'hC003,31'h7FFFFFFF,
      31'h7FFFFFFF,0,2));
    vecs.push_back(mk(0,0,0,0, 1,16'hD004,0,
      1,0,0,16'hC003,31'h7FFFFFFF,0,0,3));
    vecs.push_back(mk(1,1,1,31'h100, 0,0,0,
      0,0,1,16'hD004,0,0,0,3));
    vecs.push_back(mk(0,0,0,0, 0,0,0,
      1,31'h100,0,16'hD004,0,31'h100,0,4));
    vecs.push_back(mk(0,0,0,0, 1,16'hE005,0,
      1,31'h100,0,16'hD004,0,31'h100,0,4));
    vecs.push_back(mk(0,0,0,0, 0,0,0,
      0,0,1,16'hE005,31'h100,31'h100,0,4));
    vecs.push_back(mk(1,0,0,31'h40, 0,0,0,
      0,0,1,16'hE005,31'h100,31'h100,0,4));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      set = vecs[i].set; add = vecs[i].add;
      inc = vecs[i].inc; tgt = vecs[i].tgt;
      ack = vecs[i].ack; rdata = vecs[i].rdata;
      err = vecs[i].err;
      chk_all($sformatf("vec%0d", i), vecs[i].req,
        vecs[i].addr, vecs[i].valid, vecs[i].instr,
        vecs[i].ipc, vecs[i].pc, vecs[i].fault,
        vecs[i].ir);
      step();
    end
    idle();

    // delayed ack: request held stable at 0x40
    for (int i = 0; i < 5; i++) begin
      chk_all($sformatf("wait%0d", i), 1, 31'h40, 0,
        16'hE005, 31'h100, 31'h40, 0, 5);
      step();
    end
    ack = 1; rdata = 16'hF006;
    chk_all("ackd", 1, 31'h40, 0, 16'hE005,
      31'h100, 31'h40, 0, 5);
    step();
    idle();

    // EXEC stall: no strobes for 10 cycles
    for (int i = 0; i < 10; i++) begin
      chk_all($sformatf("stall%0d", i), 0, 0, 1,
        16'hF006, 31'h40, 31'h40, 0, 5);
      step();
    end
    inc = 1;
    step();
    idle();
    chk_all("inc41", 1, 31'h41, 0, 16'hF006,
      31'h40, 31'h41, 0, 6);

    // bus error -> sticky fault
    ack = 1; err = 1; rdata = 16'h7777;
    step();
    idle();
    chk_all("flt0", 0, 0, 0, 16'hF006,
      31'h40, 31'h41, 1, 6);
    set = 1; inc = 1; tgt = 31'h222;
    ack = 1; rdata = 16'h1111;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("flt%0d", i + 1), 0, 0, 0,
        16'hF006, 31'h40, 31'h41, 1, 6);
    end
    do_reset();
    chk_all("rst1", 0, 0, 0, 16'h0, 0, 0, 0, 0);
    step();
    chk_all("boot1", 1, 0, 0, 16'h0, 0, 0, 0, 0);

    // reset mid-FETCH, stale ack during BOOT
    ack = 1; rdata = 16'h1357;
    step();
    ack = 0;
    inc = 1;
    step();
    idle();
    chk_all("pre", 1, 1, 0, 16'h1357, 0, 1, 0, 1);
    do_reset();
    ack = 1; rdata = 16'h1234;
    chk_all("rst2", 0, 0, 0, 16'h0, 0, 0, 0, 0);
    step();
    chk_all("stale", 1, 0, 0, 16'h0, 0, 0, 0, 0);
    rdata = 16'h5A5A;
    step();
    idle();
    chk_all("fresh", 0, 0, 1, 16'h5A5A, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
